// File: rtl/adda_pkg.sv
// Shared definitions for the ADDA sample path (DDS transmit end and ADC receive end).
package adda_pkg;

  localparam int ADC_W  = 14;
  localparam int AXIS_W = 16;

  // Offset-binary midpoint: this code represents zero in the signed domain.
  localparam logic [ADC_W-1:0] ADC_MID = 14'h2000;

  // Capture sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cap_state_t;

  // Offset binary to two's complement: flip the MSB, then sign-extend to AXIS_W.
  function automatic logic [AXIS_W-1:0] offset_to_signed(input logic [ADC_W-1:0] word);
    logic [ADC_W-1:0] twos;
    twos = word ^ ADC_MID;
    return {{(AXIS_W - ADC_W){twos[ADC_W-1]}}, twos};
  endfunction

  // Two's complement to offset binary, used by the DDS side before the DAC.
  function automatic logic [ADC_W-1:0] signed_to_offset(input logic [ADC_W-1:0] code);
    return code ^ ADC_MID;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and drop indication.
module sample_fifo #(
  parameter int WIDTH      = 17,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  always_comb begin
    pop_ok  = pop && (level != '0);
    push_ok = push && ((level < DEPTH_L) || pop_ok);
    drop    = push && !push_ok;
  end

  // Head entry falls through; reads zero while empty so outputs are clean after reset.
  always_comb begin
    rd_data = (level != '0) ? mem[rd_ptr] : '0;
  end

  // Storage array, no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at depth; level tracks net push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture.sv
// ADC receive path: register, decimate, convert to signed, buffer, stream out.
module adc_capture
  import adda_pkg::*;
#(
  parameter int SAMPLE_RATE = 4,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADC_W-1:0]     adc_data,
  input  logic                 adc_ovr,
  input  logic                 en,
  input  logic                 clr_ovf,
  output logic                 m_tvalid,
  output logic [AXIS_W-1:0]    m_tdata,
  output logic                 m_tuser,
  input  logic                 m_tready,
  output logic                 overflow,
  output logic [DEPTH_LOG2:0]  level
);

  // Counter is kept at least one bit wide; the mask makes SAMPLE_RATE=0 a constant zero.
  localparam int CW = (SAMPLE_RATE > 0) ? SAMPLE_RATE : 1;
  localparam logic [CW-1:0] CNT_MASK = CW'((1 << SAMPLE_RATE) - 1);

  logic [ADC_W-1:0] in_data_reg;
  logic             in_ovr_reg;
  cap_state_t       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             strobe;
  logic             drop;
  logic [AXIS_W:0]  head;

  // Input register runs every cycle, independent of the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_data_reg <= '0;
      in_ovr_reg  <= 1'b0;
    end else begin
      in_data_reg <= adc_data;
      in_ovr_reg  <= adc_ovr;
    end
  end

  // Sequencer and decimation counter; leaving RUN discards any partial interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (en) state_reg <= RUN;
        end
        RUN: begin
          if (!en) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= (cnt_reg + 1'b1) & CNT_MASK;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Capture strobe: first cycle of every decimation interval while running.
  always_comb begin
    strobe = (state_reg == RUN) && (cnt_reg == '0);
  end

  sample_fifo #(
    .WIDTH      (AXIS_W + 1),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (strobe),
    .pop     (m_tready),
    .wr_data ({in_ovr_reg, offset_to_signed(in_data_reg)}),
    .rd_data (head),
    .level   (level),
    .drop    (drop)
  );

  // Stream outputs come straight from the FIFO head.
  always_comb begin
    m_tvalid = (level != '0);
    m_tuser  = head[AXIS_W];
    m_tdata  = head[AXIS_W-1:0];
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule
